// File: rtl/ecc_62_err_collect_pkg.sv
// Shared widths, error-type encoding and capture FSM states for the ECC error collector.
package ecc_62_pkg;

  localparam int ECC_DATA_WIDTH = 62;
  localparam int ECC_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    SBIT  = 2'b00,
    DBIT  = 2'b01,
    FAULT = 2'b10
  } err_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    CAPT = 1'b1
  } capt_state_t;

  // Decoder fault outranks a double-bit error, which outranks a corrected single-bit error.
  function automatic err_type_t err_type_of(input logic dbit, input logic fault);
    if (fault) return FAULT;
    if (dbit) return DBIT;
    return SBIT;
  endfunction

endpackage

// File: rtl/ecc_62_err_collect_if.sv
// Beat stream into and out of the ECC error collector; the collector is the slave.
interface ecc_62_err_collect_if #(
  parameter int DATA_WIDTH = ecc_62_pkg::ECC_DATA_WIDTH,
  parameter int ADDR_WIDTH = ecc_62_pkg::ECC_ADDR_WIDTH
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_sbit_err;
  logic                  in_dbit_err;
  logic                  in_ecc_fault;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_poison;

  modport master (
    output in_vld, in_addr, in_data, in_sbit_err, in_dbit_err, in_ecc_fault, out_rdy,
    input  in_rdy, out_vld, out_data, out_poison
  );

  modport slave (
    input  in_vld, in_addr, in_data, in_sbit_err, in_dbit_err, in_ecc_fault, out_rdy,
    output in_rdy, out_vld, out_data, out_poison
  );
endinterface

// File: rtl/ecc_62_err_collect_sat_cnt.sv
// Saturating event counter; clr wins over the held value but a same-cycle inc still counts.
// Latency: cnt_nxt is combinational, cnt registers it. No backpressure.
module ecc_sat_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] cnt_nxt
);

  logic [CNT_WIDTH-1:0] base;

  always_comb begin
    base    = clr ? '0 : cnt;
    cnt_nxt = base;
    if (inc && !(&base)) cnt_nxt = base + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ecc_62_err_collect.sv
// ECC read-side collector: registers beats, poison-marks, counts errors, captures first error, irq.
// Latency 1, full throughput; in_rdy = ~out_vld | out_rdy, held low after a poisoned beat
// until clr when ECC_ERR_POISON_HOLD_EN is defined.
module ecc_62_err_collect
  import ecc_62_pkg::*;
#(
  parameter int DATA_WIDTH  = ECC_DATA_WIDTH,
  parameter int ADDR_WIDTH  = ECC_ADDR_WIDTH,
  parameter int CNT_WIDTH   = 8,
  parameter int SBIT_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ecc_62_err_collect_if.slave   bus,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  err_capt_vld,
  output logic [ADDR_WIDTH-1:0] err_capt_addr,
  output logic [1:0]            err_capt_type,
  output logic                  irq
);

  localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(SBIT_THRESH);

  logic                  rdy_en;
  logic                  hold;
  logic                  accept;
  logic                  poison_in;
  logic                  out_vld_q;
  logic                  out_poison_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign poison_in = bus.in_dbit_err | bus.in_ecc_fault;
  assign accept    = bus.in_vld & bus.in_rdy;

  // rdy_en keeps in_rdy low while reset is asserted, even though the stage is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

`ifdef ECC_ERR_POISON_HOLD_EN
  logic hold_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  hold_q <= 1'b0;
    else if (clr)                hold_q <= accept & poison_in;
    else if (accept & poison_in) hold_q <= 1'b1;
  end
  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif

  assign bus.in_rdy = rdy_en & ~hold & (~out_vld_q | bus.out_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q    <= 1'b0;
      out_poison_q <= 1'b0;
      data_q       <= '0;
    end else if (accept) begin
      out_vld_q    <= 1'b1;
      out_poison_q <= poison_in;
      data_q       <= bus.in_data;
    end else if (bus.out_rdy) begin
      out_vld_q    <= 1'b0;
    end
  end

  assign bus.out_vld    = out_vld_q;
  assign bus.out_poison = out_poison_q;
  assign bus.out_data   = data_q;

  // A beat flagged both sbit and dbit counts only as dbit.
  logic sbit_inc, dbit_inc, fault_inc;
  assign sbit_inc  = accept & bus.in_sbit_err & ~bus.in_dbit_err;
  assign dbit_inc  = accept & bus.in_dbit_err;
  assign fault_inc = accept & bus.in_ecc_fault;

  logic [CNT_WIDTH-1:0] sbit_nxt, dbit_nxt, fault_nxt;

  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sbit_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(sbit_inc), .cnt(sbit_cnt), .cnt_nxt(sbit_nxt)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dbit_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(dbit_inc), .cnt(dbit_cnt), .cnt_nxt(dbit_nxt)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(fault_inc), .cnt(fault_cnt), .cnt_nxt(fault_nxt)
  );

  logic sticky_dbit, sticky_fault;
  logic sticky_dbit_nxt, sticky_fault_nxt, irq_nxt;

  always_comb begin
    sticky_dbit_nxt  = (clr ? 1'b0 : sticky_dbit) | dbit_inc;
    sticky_fault_nxt = (clr ? 1'b0 : sticky_fault) | fault_inc;
    irq_nxt          = sticky_dbit_nxt | sticky_fault_nxt | (sbit_nxt >= THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_dbit  <= 1'b0;
      sticky_fault <= 1'b0;
      irq          <= 1'b0;
    end else begin
      sticky_dbit  <= sticky_dbit_nxt;
      sticky_fault <= sticky_fault_nxt;
      irq          <= irq_nxt;
    end
  end

  capt_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] capt_addr, capt_addr_nxt;
  err_type_t             capt_type, capt_type_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      capt_addr <= '0;
      capt_type <= SBIT;
    end else begin
      state     <= state_nxt;
      capt_addr <= capt_addr_nxt;
      capt_type <= capt_type_nxt;
    end
  end

  // clr is applied before a same-cycle beat, so that beat can open a fresh record.
  always_comb begin
    state_nxt     = state;
    capt_addr_nxt = capt_addr;
    capt_type_nxt = capt_type;
    if (clr) begin
      state_nxt     = IDLE;
      capt_addr_nxt = '0;
      capt_type_nxt = SBIT;
    end
    if (state_nxt == IDLE && accept &&
        (bus.in_sbit_err | bus.in_dbit_err | bus.in_ecc_fault)) begin
      state_nxt     = CAPT;
      capt_addr_nxt = bus.in_addr;
      capt_type_nxt = err_type_of(bus.in_dbit_err, bus.in_ecc_fault);
    end
  end

  assign err_capt_vld  = (state == CAPT);
  assign err_capt_addr = capt_addr;
  assign err_capt_type = capt_type;

endmodule
